dmem_uart_dumper: RTL and testbench

//  Board-level companion to the 16-bit multicycle core. Sweeps the core's data-memory

---
 rtl/dmem_uart_dumper.sv | 188 ++++++++++++++++++
 tb/tb_dmem_uart_dumper.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_uart_dumper.sv
// Sweeps the core's data-memory debug index and streams each word over an 8N1 UART
// as an ASCII line "AA:DDDD\r\n" (uppercase hex), one line per address.
module dmem_uart_dumper #(
   parameter int unsigned CLKS_PER_BIT  = 868,
   parameter int unsigned ADDR_W        = 6,
   parameter int unsigned DATA_W        = 16,
   parameter int unsigned NUM_WORDS     = 64,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] user_in,
   input  logic [DATA_W-1:0] user_read,
   output logic              uart_tx,
   output logic              busy,
   output logic              done
);

   localparam int unsigned NUM_DIGITS = DATA_W / 4;
   localparam int unsigned NUM_CHARS  = NUM_DIGITS + 5;
   localparam int unsigned TMR_W      = $clog2(CLKS_PER_BIT);
   localparam int unsigned SET_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned CHR_W      = $clog2(NUM_CHARS);

   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_WORDS - 1);
   localparam logic [TMR_W-1:0]  LAST_TMR    = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [SET_W-1:0]  LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [CHR_W-1:0]  LAST_CHR    = CHR_W'(NUM_CHARS - 1);
   localparam logic [CHR_W-1:0]  FIRST_DIG   = CHR_W'(3);
   localparam logic [CHR_W-1:0]  CR_CHR      = CHR_W'(3 + NUM_DIGITS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET_ADDR,
      S_SETTLE,
      S_SEND,
      S_FINISH
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   user_in_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [SET_W-1:0]    settle_q, settle_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [3:0]          bit_q, bit_d;
   logic [CHR_W-1:0]    chr_q, chr_d;
   logic                uart_tx_d, busy_d, done_d;
   logic [7:0]          cur_char;
   logic [7:0]          addr8;

   // Nibble to uppercase ASCII hex digit
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + 8'(n);
      else           return 8'h37 + 8'(n);
   endfunction

   // Character currently being serialised; data digits come from the top of a shifting copy
   always_comb begin
      addr8    = 8'(addr_q);
      cur_char = 8'h0A;
      if (chr_q == CHR_W'(0))       cur_char = hex_ascii(addr8[7:4]);
      else if (chr_q == CHR_W'(1))  cur_char = hex_ascii(addr8[3:0]);
      else if (chr_q == CHR_W'(2))  cur_char = 8'h3A;
      else if (chr_q < CR_CHR)      cur_char = hex_ascii(data_q[DATA_W-1 -: 4]);
      else if (chr_q == CR_CHR)     cur_char = 8'h0D;
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         user_in  <= '0;
         data_q   <= '0;
         settle_q <= '0;
         tmr_q    <= '0;
         bit_q    <= '0;
         chr_q    <= '0;
         uart_tx  <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         user_in  <= user_in_d;
         data_q   <= data_d;
         settle_q <= settle_d;
         tmr_q    <= tmr_d;
         bit_q    <= bit_d;
         chr_q    <= chr_d;
         uart_tx  <= uart_tx_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      user_in_d = user_in;
      data_d    = data_q;
      settle_d  = settle_q;
      tmr_d     = tmr_q;
      bit_d     = bit_q;
      chr_d     = chr_q;
      uart_tx_d = uart_tx;
      busy_d    = busy;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            uart_tx_d = 1'b1;
            busy_d    = 1'b0;
            if (start) begin
               state_d = S_SET_ADDR;
               addr_d  = '0;
               busy_d  = 1'b1;
            end
         end

         S_SET_ADDR: begin
            user_in_d = addr_q;
            settle_d  = '0;
            state_d   = S_SETTLE;
         end

         S_SETTLE: begin
            if (settle_q == LAST_SETTLE) begin
               // Single capture point: user_read is not looked at again for this word
               data_d    = user_read;
               state_d   = S_SEND;
               tmr_d     = '0;
               bit_d     = '0;
               chr_d     = '0;
               uart_tx_d = 1'b0;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end

         S_SEND: begin
            if (tmr_q != LAST_TMR) begin
               tmr_d = tmr_q + TMR_W'(1);
            end else begin
               tmr_d = '0;
               if (bit_q != 4'd9) begin
                  // bit_q 0..7 -> next is data bit bit_q; bit_q 8 -> next is stop
                  bit_d     = bit_q + 4'd1;
                  uart_tx_d = (bit_q == 4'd8) ? 1'b1 : cur_char[bit_q[2:0]];
               end else begin
                  bit_d = '0;
                  if (chr_q >= FIRST_DIG && chr_q < CR_CHR)
                     data_d = data_q << 4;
                  if (chr_q != LAST_CHR) begin
                     chr_d     = chr_q + CHR_W'(1);
                     uart_tx_d = 1'b0;
                  end else begin
                     chr_d     = '0;
                     uart_tx_d = 1'b1;
                     if (addr_q == LAST_ADDR) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                     end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_SET_ADDR;
                     end
                  end
               end
            end
         end

         S_FINISH: begin
            busy_d    = 1'b0;
            user_in_d = '0;
            addr_d    = '0;
            state_d   = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dmem_uart_dumper.sv
// Bench for dmem_uart_dumper: decodes uart_tx and checks lines against a scoreboard queue.
module tb_dmem_uart_dumper;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst_a, rst_b, start_a, start_b, ovr, sel;
   logic [5:0]  user_in_a, user_in_b;
   logic [15:0] read_a, read_b;
   logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;
   logic        tx_s, busy_s, done_s, rst_s;

   int          vectors = 0;
   int          miscompares = 0;
   int          busy_cnt = 0;
   int          done_cnt = 0;
   logic [7:0]  exp_q[$];
   bit          rx_act = 1'b0;
   int          rx_cyc = 0;
   logic [7:0]  rx_byte = 8'h00;

   always #5 clk = ~clk;

   // Memory models behind each debug port
   assign read_a = ovr ? 16'hFFFF : 16'hA5F0 + 16'(user_in_a);
   assign read_b = 16'(user_in_b) * 16'h0101;

   assign tx_s   = sel ? tx_b   : tx_a;
   assign busy_s = sel ? busy_b : busy_a;
   assign done_s = sel ? done_b : done_a;
   assign rst_s  = sel ? rst_b  : rst_a;

   dmem_uart_dumper #(
      .CLKS_PER_BIT(CPB), .ADDR_W(6), .DATA_W(16), .NUM_WORDS(4), .SETTLE_CYCLES(2)
   ) dut_a (
      .clk(clk), .rst(rst_a), .start(start_a), .user_in(user_in_a),
      .user_read(read_a), .uart_tx(tx_a), .busy(busy_a), .done(done_a)
   );

   dmem_uart_dumper #(
      .CLKS_PER_BIT(CPB), .ADDR_W(6), .DATA_W(16), .NUM_WORDS(64), .SETTLE_CYCLES(2)
   ) dut_b (
      .clk(clk), .rst(rst_b), .start(start_b), .user_in(user_in_b),
      .user_read(read_b), .uart_tx(tx_b), .busy(busy_b), .done(done_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_line(input logic [7:0] a, input logic [15:0] d, input int n);
      string      hx = "0123456789ABCDEF";
      logic [7:0] ln[9];
      ln[0] = hx[int'(a[7:4])];
      ln[1] = hx[int'(a[3:0])];
      ln[2] = 8'h3A;
      ln[3] = hx[int'(d[15:12])];
      ln[4] = hx[int'(d[11:8])];
      ln[5] = hx[int'(d[7:4])];
      ln[6] = hx[int'(d[3:0])];
      ln[7] = 8'h0D;
      ln[8] = 8'h0A;
      for (int i = 0; i < n; i++) exp_q.push_back(ln[i]);
   endtask

   // Advance one cycle; at the falling edge update monitors and the UART decoder
   task automatic tick();
      @(negedge clk);
      if (busy_s) busy_cnt++;
      if (done_s) done_cnt++;
      if (rst_s) begin
         rx_act = 1'b0;
      end else if (!rx_act) begin
         if (tx_s === 1'b0) begin
            rx_act = 1'b1;
            rx_cyc = 0;
         end
      end else begin
         rx_cyc++;
         if (rx_cyc == CPB / 2) begin
            chk("start_bit", 32'(tx_s), 32'h0);
         end else if (rx_cyc < 9 * CPB && (rx_cyc % CPB) == CPB / 2) begin
            rx_byte[3'(rx_cyc / CPB - 1)] = tx_s;
         end else if (rx_cyc == 9 * CPB + CPB / 2) begin
            chk("stop_bit", 32'(tx_s), 32'h1);
            vectors++;
            assert (exp_q.size() > 0) else begin
               miscompares++;
               $error("FAIL extra_char observed=%02h expected=none", rx_byte);
            end
            if (exp_q.size() > 0) chk("rx_char", 32'(rx_byte), 32'(exp_q.pop_front()));
            rx_act = 1'b0;
         end
      end
   endtask

   task automatic wait_done(input int budget);
      int n  = 0;
      int d0 = done_cnt;
      while (done_cnt == d0 && n < budget) begin
         tick();
         n++;
      end
      chk("done_seen", 32'(done_cnt - d0), 32'h1);
   endtask

   initial begin
      int bad;
      int b0;
      int d0;
      rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0; ovr = 1'b0; sel = 1'b0;

      // Reset and idle
      repeat (5) tick();
      chk("rst_tx", 32'(tx_a), 32'h1);
      chk("rst_busy", 32'(busy_a), 32'h0);
      chk("rst_done", 32'(done_a), 32'h0);
      chk("rst_user_in", 32'(user_in_a), 32'h0);
      rst_a = 1'b0;
      bad = 0;
      repeat (100) begin
         tick();
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || user_in_a !== 6'd0) bad++;
      end
      chk("idle_violations", 32'(bad), 32'h0);

      // Basic dump with run-length check
      for (int a = 0; a < 4; a++) push_line(8'(a), 16'hA5F0 + 16'(a), 9);
      b0 = busy_cnt; d0 = done_cnt;
      start_a = 1'b1; tick(); start_a = 1'b0;
      chk("busy_rise", 32'(busy_a), 32'h1);
      wait_done(2000);
      repeat (50) tick();
      chk("run_length", 32'(busy_cnt - b0), 32'd1453);
      chk("done_pulses", 32'(done_cnt - d0), 32'h1);
      chk("lines_left", 32'(exp_q.size()), 32'h0);
      chk("user_in_after", 32'(user_in_a), 32'h0);
      chk("busy_after", 32'(busy_a), 32'h0);

      // Capture isolation and start while busy
      for (int a = 0; a < 4; a++) push_line(8'(a), 16'hA5F0 + 16'(a), 9);
      b0 = busy_cnt; d0 = done_cnt;
      start_a = 1'b1; tick(); start_a = 1'b0;
      repeat (6) tick();
      ovr = 1'b1;
      repeat (294) tick();
      ovr = 1'b0;
      repeat (200) tick();
      start_a = 1'b1; tick(); start_a = 1'b0;
      wait_done(2000);
      repeat (50) tick();
      chk("run_length_iso", 32'(busy_cnt - b0), 32'd1453);
      chk("done_pulses_iso", 32'(done_cnt - d0), 32'h1);
      chk("lines_left_iso", 32'(exp_q.size()), 32'h0);

      // Reset in the middle of the data bits of char 5 of line 1
      push_line(8'h00, 16'hA5F0, 9);
      push_line(8'h01, 16'hA5F1, 5);
      start_a = 1'b1; tick(); start_a = 1'b0;
      repeat (586) tick();
      chk("user_in_pre_rst", 32'(user_in_a), 32'h1);
      chk("tx_pre_rst", 32'(tx_a), 32'h0);
      rst_a = 1'b1;
      #1;
      chk("tx_on_rst", 32'(tx_a), 32'h1);
      chk("user_in_on_rst", 32'(user_in_a), 32'h0);
      chk("busy_on_rst", 32'(busy_a), 32'h0);
      tick();
      chk("partial_left", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
      repeat (3) tick();
      rst_a = 1'b0;
      repeat (10) tick();
      for (int a = 0; a < 4; a++) push_line(8'(a), 16'hA5F0 + 16'(a), 9);
      d0 = done_cnt;
      start_a = 1'b1; tick(); start_a = 1'b0;
      wait_done(2000);
      repeat (50) tick();
      chk("done_pulses_rr", 32'(done_cnt - d0), 32'h1);
      chk("lines_left_rr", 32'(exp_q.size()), 32'h0);

      // Full 64-word range
      rst_b = 1'b0; sel = 1'b1;
      repeat (10) tick();
      for (int a = 0; a < 64; a++) push_line(8'(a), 16'(a) * 16'h0101, 9);
      b0 = busy_cnt; d0 = done_cnt;
      start_b = 1'b1; tick(); start_b = 1'b0;
      wait_done(30000);
      repeat (200) tick();
      chk("run_length_full", 32'(busy_cnt - b0), 32'd23233);
      chk("done_pulses_full", 32'(done_cnt - d0), 32'h1);
      chk("lines_left_full", 32'(exp_q.size()), 32'h0);
      chk("user_in_after_full", 32'(user_in_b), 32'h0);
      chk("busy_after_full", 32'(busy_b), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
